retire_trace_sched: RTL and testbench

//  Collects instructions retired from up to NUM_PORTS retire slots per cycle and buffers them in program order.

---
 rtl/retire_trace_pkg.sv | 15 +
 rtl/retire_trace_fifo.sv | 63 ++++++
 rtl/retire_trace_sched.sv | 120 ++++++++++++
 tb/tb_retire_trace_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trace_pkg.sv
// Shared types and sizing helpers for the retire trace scheduler.
package retire_trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } trace_entry_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/retire_trace_fifo.sv
// Multi-write, single-read circular buffer of trace entries.
// Writes are compacted (wr_en contiguous from bit 0); occupancy tracked by count, never by pointer equality.
module retire_trace_fifo
    import retire_trace_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = ptr_width(DEPTH) + 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [NUM_PORTS-1:0]          wr_en,
    input  trace_entry_t [NUM_PORTS-1:0]  wr_data,
    input  logic                          rd_en,
    output trace_entry_t                  rd_data,
    output logic [CNT_W-1:0]              count
);

    localparam int PTR_W = ptr_width(DEPTH);

    trace_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] n_wr;

    always_comb begin
        n_wr = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            n_wr = n_wr + CNT_W'(wr_en[j]);
        end
    end

    // DEPTH is a power of two, so pointer arithmetic wraps naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_wr[PTR_W-1:0];
            rd_ptr <= rd_ptr + PTR_W'(rd_en);
            count  <= count + n_wr - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clock) begin
        if (!flush) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (wr_en[j]) begin
                    mem[wr_ptr + PTR_W'(j)] <= wr_data[j];
                end
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/retire_trace_sched.sv
// Orders a multi-slot retire stream into a single valid/ready trace stream with sequence numbers.
// Optional TRACE_NOP_FILTER_EN drops all-zero instruction words before they are buffered.
module retire_trace_sched
    import retire_trace_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 16,
    parameter int SEQ_W     = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic [NUM_PORTS-1:0]    ret_valid,
    input  logic [NUM_PORTS*32-1:0] ret_pc,
    input  logic [NUM_PORTS*32-1:0] ret_inst,
    output logic                    ret_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_inst,
    output logic [SEQ_W-1:0]        out_seq,
    output logic                    overflow
);

    localparam int CNT_W = ptr_width(DEPTH) + 1;

    trace_entry_t [NUM_PORTS-1:0] slot;
    trace_entry_t [NUM_PORTS-1:0] comp;
    logic [NUM_PORTS-1:0]         keep;
    logic [NUM_PORTS-1:0]         comp_en;
    logic [NUM_PORTS-1:0]         fifo_wr_en;
    trace_entry_t                 head;
    logic [CNT_W-1:0]             count;
    logic                         accept;
    logic                         load;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            slot[i].pc   = ret_pc[i*32 +: 32];
            slot[i].inst = ret_inst[i*32 +: 32];
        end
    end

    always_comb begin
        keep = ret_valid;
`ifdef TRACE_NOP_FILTER_EN
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ret_inst[i*32 +: 32] == NOP_WORD) begin
                keep[i] = 1'b0;
            end
        end
`endif
    end

    // Pack surviving slots down to the lowest write lanes, preserving slot order.
    always_comb begin
        int idx;
        idx     = 0;
        comp    = '0;
        comp_en = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (keep[i]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (k == idx) begin
                        comp[k]    = slot[i];
                        comp_en[k] = 1'b1;
                    end
                end
                idx = idx + 1;
            end
        end
    end

    assign ret_ready  = (count <= CNT_W'(DEPTH - NUM_PORTS));
    assign accept     = ret_ready && !flush;
    assign fifo_wr_en = accept ? comp_en : '0;
    assign load       = !flush && (count != '0) && (!out_valid || out_ready);

    retire_trace_fifo #(
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .wr_en   (fifo_wr_en),
        .wr_data (comp),
        .rd_en   (load),
        .rd_data (head),
        .count   (count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
            out_seq   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (|ret_valid && !ret_ready) begin
                overflow <= 1'b1;
            end
            if (out_valid && out_ready) begin
                out_seq <= out_seq + SEQ_W'(1);
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
                out_pc    <= head.pc;
                out_inst  <= head.inst;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_retire_trace_sched.sv
// Randomised and directed bench for retire_trace_sched against a queue-based trace model.
module tb_retire_trace_sched;

    localparam int NP    = 2;
    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              flush;
    logic [NP-1:0]     ret_valid;
    logic [NP*32-1:0]  ret_pc;
    logic [NP*32-1:0]  ret_inst;
    logic              ret_ready;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_inst;
    logic [SEQ_W-1:0]  out_seq;
    logic              overflow;

    retire_trace_sched #(.NUM_PORTS(NP), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .ret_inst  (ret_inst),
        .ret_ready (ret_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_seq   (out_seq),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    // Retire valids must be contiguous from slot 0.
    always @(posedge clock) begin
        if (reset_n) begin
            assert (((ret_valid + NP'(1)) & ret_valid) == '0)
                else $error("non-contiguous ret_valid %b", ret_valid);
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    // Trace model: buffered entries as a queue plus the presented entry.
    logic [63:0]      mq[$];
    logic             m_valid;
    logic [31:0]      m_pc;
    logic [31:0]      m_inst;
    logic [SEQ_W-1:0] m_seq;
    logic             m_ovf;

    logic [31:0] g_pc   [NP];
    logic [31:0] g_inst [NP];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic m_ready();
        return mq.size() <= DEPTH - NP;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_valid = 1'b0;
        m_pc    = '0;
        m_inst  = '0;
        m_seq   = '0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void m_step(input logic [NP-1:0] v, input logic fl, input logic rdy);
        logic rd_ok;
        logic [63:0] e;
        rd_ok = m_ready();
        if (v != '0 && !rd_ok) m_ovf = 1'b1;
        if (m_valid && rdy) m_seq = m_seq + SEQ_W'(1);
        if (fl) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            if (mq.size() > 0 && (!m_valid || rdy)) begin
                e = mq.pop_front();
                m_pc    = e[63:32];
                m_inst  = e[31:0];
                m_valid = 1'b1;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            if (rd_ok) begin
                for (int i = 0; i < NP; i++) begin
`ifdef TRACE_NOP_FILTER_EN
                    if (v[i] && g_inst[i] != 32'h0) mq.push_back({g_pc[i], g_inst[i]});
`else
                    if (v[i]) mq.push_back({g_pc[i], g_inst[i]});
`endif
                end
            end
        end
    endfunction

    task automatic check_all();
        chk("out_valid", out_valid, m_valid);
        chk("ret_ready", ret_ready, m_ready());
        chk("overflow",  overflow,  m_ovf);
        chk("out_seq",   out_seq,   m_seq);
        if (m_valid) begin
            chk("out_pc",   out_pc,   m_pc);
            chk("out_inst", out_inst, m_inst);
        end
    endtask

    task automatic step(input logic [NP-1:0] v, input logic fl, input logic rdy);
        ret_valid = v;
        flush     = fl;
        out_ready = rdy;
        for (int i = 0; i < NP; i++) begin
            ret_pc[i*32 +: 32]   = g_pc[i];
            ret_inst[i*32 +: 32] = g_inst[i];
        end
        m_step(v, fl, rdy);
        @(negedge clock);
        check_all();
    endtask

    task automatic rand_slots();
        for (int i = 0; i < NP; i++) begin
            g_pc[i]   = $urandom() & 32'hFFFF_FFFC;
            g_inst[i] = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom() | 32'h1);
        end
    endtask

    initial begin
        int groups;
        logic [SEQ_W-1:0] s_saved;
        logic [NP-1:0] v;

        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        ret_valid = '0; ret_pc = '0; ret_inst = '0;
        for (int i = 0; i < NP; i++) begin g_pc[i] = '0; g_inst[i] = 32'h1; end
        m_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        check_all();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ret_ready", ret_ready, 1);
        chk("rst_out_seq",   out_seq,   0);
        chk("rst_out_pc",    out_pc,    0);
        chk("rst_overflow",  overflow,  0);

        // Single two-slot group drains in slot order.
        g_pc[0] = 32'h400; g_pc[1] = 32'h404; g_inst[0] = 32'h1111; g_inst[1] = 32'h2222;
        step(2'b11, 0, 1);
        step(2'b00, 0, 1);
        chk("t1_pc0", out_pc, 32'h400);
        chk("t1_seq0", out_seq, 0);
        step(2'b00, 0, 1);
        chk("t1_pc1", out_pc, 32'h404);
        chk("t1_seq1", out_seq, 1);
        step(2'b00, 0, 1);
        chk("t1_drained", out_valid, 0);

        // Backpressure: fill while the logger stalls.
        groups = 0;
        for (int c = 0; c < 10; c++) begin
            rand_slots();
            g_inst[0] = g_inst[0] | 32'h1; g_inst[1] = g_inst[1] | 32'h1;
            v = m_ready() ? 2'b11 : 2'b00;
            if (v != '0) groups++;
            step(v, 0, 0);
        end
        chk("t2_groups", groups, 8);
        chk("t2_full_not_ready", ret_ready, 0);
        chk("t2_no_overflow", overflow, 0);

        // Group while full is dropped and sets sticky overflow.
        rand_slots();
        step(2'b11, 0, 0);
        chk("t3_overflow", overflow, 1);
        step(2'b00, 0, 0);
        chk("t3_overflow_sticky", overflow, 1);

        for (int t = 0; t < 60 && (m_valid || mq.size() > 0); t++) step(2'b00, 0, 1);
        chk("t2_drain_done", out_valid, 0);
        chk("t2_final_seq", out_seq, 18);

        // Boundary: at the last ready occupancy, 1-in/1-out keeps count constant.
        rand_slots(); g_inst[0] = 32'h5;
        step(2'b01, 0, 0);
        for (int t = 0; t < 20 && mq.size() < DEPTH - NP; t++) begin
            rand_slots(); g_inst[0] = 32'h7; g_inst[1] = 32'h9;
            step(2'b11, 0, 0);
        end
        chk("t4_ready_at_14", ret_ready, 1);
        for (int t = 0; t < 6; t++) begin
            rand_slots(); g_inst[0] = 32'h3;
            step(2'b01, 0, 1);
            chk("t4_ready_const", ret_ready, 1);
        end
        rand_slots(); g_inst[0] = 32'h3; g_inst[1] = 32'h3;
        step(2'b11, 0, 1);
        chk("t4_ready_drop_15", ret_ready, 0);

        // Flush with entries buffered and an entry presented.
        for (int t = 0; t < 30 && mq.size() > 5; t++) step(2'b00, 0, 1);
        chk("t5_valid_before", out_valid, 1);
        rand_slots();
        step(2'b11, 1, 0);
        chk("t5_valid_after_flush", out_valid, 0);
        chk("t5_ready_after_flush", ret_ready, 1);
        s_saved = out_seq;
        g_pc[0] = 32'hABC0; g_inst[0] = 32'h77;
        step(2'b01, 0, 0);
        step(2'b00, 0, 0);
        chk("t5_pc", out_pc, 32'hABC0);
        chk("t5_seq_continues", out_seq, s_saved);
        step(2'b00, 0, 1);

`ifdef TRACE_NOP_FILTER_EN
        for (int t = 0; t < 40 && (m_valid || mq.size() > 0); t++) step(2'b00, 0, 1);
        s_saved = out_seq;
        g_pc[0] = 32'h800; g_inst[0] = 32'h0;
        g_pc[1] = 32'h804; g_inst[1] = 32'h2408_0005;
        step(2'b11, 0, 1);
        step(2'b00, 0, 1);
        chk("t6_pc", out_pc, 32'h804);
        chk("t6_inst", out_inst, 32'h2408_0005);
        step(2'b00, 0, 1);
        chk("t6_single_entry", out_valid, 0);
        chk("t6_seq_plus1", out_seq, s_saved + SEQ_W'(1));
`endif

        // Asynchronous reset with a held output entry.
        rand_slots(); g_inst[0] = 32'h9; g_inst[1] = 32'hB;
        step(2'b11, 0, 0);
        step(2'b00, 0, 0);
        chk("rst_mid_held", out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_overflow", overflow, 0);
        chk("rst_mid_seq", out_seq, 0);
        m_reset();
        ret_valid = '0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check_all();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            int r;
            rand_slots();
            r = $urandom_range(0, 2);
            v = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            step(v, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
